// File: rtl/race_pkg.sv
// race_pkg: encodings, FSM states and rest-level helper shared by race-logic operators
package race_pkg;
  typedef enum logic [1:0] {ENC_RISING, ENC_FALLING, ENC_PULSE} enc_e;
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  function automatic logic rest_level(enc_e enc);
    return enc == ENC_FALLING;
  endfunction
endpackage

// File: rtl/temporal_arrival_det.sv
// temporal_arrival_det: first-arrival edge detector for one temporal line within a gamma cycle
module temporal_arrival_det import race_pkg::*; #(
  parameter enc_e ENCODING = ENC_RISING
) (
  input  logic clk,
  input  logic grst_n,
  input  logic clear,
  input  logic run,
  input  logic s,
  output logic arrive
);
  localparam logic REST = rest_level(ENCODING);
  logic prev, seen;
  // prev starts at rest, so a line already active at t=0 arrives at t=0
  assign arrive = run & ~seen & (prev == REST) & (s != REST);
  always_ff @(posedge clk or negedge grst_n)
    if (!grst_n) begin
      prev <= REST;
      seen <= 1'b0;
    end else if (clear) begin
      prev <= REST;
      seen <= 1'b0;
    end else if (run) begin
      prev <= s;
      seen <= seen | arrive;
    end
endmodule

// File: rtl/mux_t_t_t_n.sv
// mux_t_t_t_n: clocked race-logic temporal mux; define MUX_T_TIMESTAMP_EN for match_valid/match_time/match_idx
module mux_t_t_t_n import race_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8,
  parameter enc_e ENCODING = ENC_RISING,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH),
  localparam int IW = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  grst_n,
  input  logic                  gamma_start,
  input  logic [NUM_INPUTS-1:0] inputs,
  input  logic                  select_line,
  output logic                  y,
  output logic                  busy
`ifdef MUX_T_TIMESTAMP_EN
  ,
  output logic                  match_valid,
  output logic [TW-1:0]         match_time,
  output logic [IW-1:0]         match_idx
`endif
);
  localparam logic REST = rest_level(ENCODING);
  localparam logic [TW-1:0] T_END = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0] P_LEN = TW'(PULSE_WIDTH - 1);
  state_e st;
  logic [TW-1:0] t, pcnt;
  logic act, matched, run, hit, last;
  logic [NUM_INPUTS:0] lines, arr;
  assign lines = {select_line, inputs};
  assign run = st == ST_RUN;
  assign busy = run;
  assign y = act ^ REST;
  assign hit = run & ~gamma_start & ~matched & arr[NUM_INPUTS] & |arr[NUM_INPUTS-1:0];
  assign last = run & ~gamma_start & (t == T_END);
  for (genvar i = 0; i <= NUM_INPUTS; i++) begin : g_det
    temporal_arrival_det #(.ENCODING(ENCODING)) u_det (
      .clk(clk),
      .grst_n(grst_n),
      .clear(gamma_start),
      .run(run),
      .s(lines[i]),
      .arrive(arr[i])
    );
  end
  always_ff @(posedge clk or negedge grst_n)
    if (!grst_n) begin
      st <= ST_IDLE;
      t <= '0;
      pcnt <= '0;
      act <= 1'b0;
      matched <= 1'b0;
    end else if (gamma_start) begin
      st <= ST_RUN;
      t <= '0;
      pcnt <= '0;
      act <= 1'b0;
      matched <= 1'b0;
    end else if (run) begin
      t <= last ? '0 : t + TW'(1);
      st <= last ? ST_IDLE : ST_RUN;
      if (last) begin
        act <= 1'b0;
        matched <= 1'b0;
      end else if (hit) begin
        act <= 1'b1;
        matched <= 1'b1;
        pcnt <= P_LEN;
      end else if (ENCODING == ENC_PULSE && act) begin
        act <= pcnt != '0;
        pcnt <= pcnt - TW'(1);
      end
    end
`ifdef MUX_T_TIMESTAMP_EN
  logic [IW-1:0] low;
  always_comb begin
    low = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) if (arr[k]) low = IW'(k);
  end
  // a match in the final slot still counts, so report matched | hit
  always_ff @(posedge clk or negedge grst_n)
    if (!grst_n) begin
      match_valid <= 1'b0;
      match_time <= '0;
      match_idx <= '0;
    end else begin
      match_valid <= last & (matched | hit);
      if (hit) begin
        match_time <= t;
        match_idx <= low;
      end
    end
`endif
endmodule

// File: tb/tb_mux_t_t_t_n.sv
// tb_mux_t_t_t_n: bench for mux_t_t_t_n across all three encodings; define MUX_T_TIMESTAMP_EN to also check timestamps
module tb_mux_t_t_t_n;
  import race_pkg::*;
  localparam int N = 4, G = 16, PW = 8;
  logic clk = 1'b0, grst_n = 1'b0, gamma_start = 1'b0, select_line = 1'b0;
  logic [N-1:0] inputs = '0;
  logic [2:0] ys, bs;
  logic [N:0] w [G];
  int n_cmp = 0, n_err = 0;
  bit pend = 0;
`ifdef MUX_T_TIMESTAMP_EN
  logic [2:0] mv;
  logic [3:0] mt [3];
  logic [1:0] mi [3];
`endif
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_t_t_t_n #(
      .NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW),
      .ENCODING(g == 0 ? ENC_RISING : g == 1 ? ENC_FALLING : ENC_PULSE)
    ) u_dut (
      .clk(clk), .grst_n(grst_n), .gamma_start(gamma_start), .inputs(inputs),
      .select_line(select_line), .y(ys[g]), .busy(bs[g])
`ifdef MUX_T_TIMESTAMP_EN
      , .match_valid(mv[g]), .match_time(mt[g]), .match_idx(mi[g])
`endif
    );
  end
  initial begin
    #1000000;
    $display("FAIL timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input int e, input int k, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s enc=%0d t=%0d observed=%0d expected=%0d", tag, e, k, obs, exp);
    end
  endtask
  function automatic int arr_t(input int e, input int l);
    logic r;
    r = (e == 1);
    for (int t = 0; t < G; t++) if (w[t][l] != r) return t;
    return -1;
  endfunction
  function automatic int match_t(input int e, output int idx);
    int s;
    idx = 0;
    s = arr_t(e, N);
    if (s < 0) return -1;
    for (int i = 0; i < N; i++) if (arr_t(e, i) == s) begin
      idx = i;
      return s;
    end
    return -1;
  endfunction
  function automatic logic act_exp(input int e, input int k, input int m);
    return m >= 0 && k > m && (e != 2 || k - m <= PW);
  endfunction
  task automatic step(input int l, input int a, input logic p);
    for (int t = 0; t < G; t++) w[t][l] = p ^ (t >= a);
  endtask
  task automatic clr_w();
    for (int l = 0; l <= N; l++) step(l, G, 1'b0);
  endtask
  task automatic rand_w();
    for (int l = 0; l <= N; l++) begin
      int a;
      logic p;
      a = $urandom_range(0, 6) * 3;
      p = 1'($urandom_range(0, 1));
      for (int t = 0; t < G; t++) w[t][l] = p ^ (t >= a) ^ ((t > a) && ($urandom_range(0, 3) == 0));
    end
  endtask
  task automatic idle_chk(input string tag);
    for (int e = 0; e < 3; e++) begin
      chk({tag, "_busy"}, e, -1, 8'(bs[e]), 8'd0);
      chk({tag, "_y"}, e, -1, 8'(ys[e]), 8'(e == 1));
`ifdef MUX_T_TIMESTAMP_EN
      chk({tag, "_mv"}, e, -1, 8'(mv[e]), 8'd0);
`endif
    end
  endtask
  task automatic gamma(input int ab, input bit rst_abort);
    int m [3];
    int ix [3];
    for (int e = 0; e < 3; e++) m[e] = match_t(e, ix[e]);
    for (int k = 0; k < G; k++) begin
      @(posedge clk);
      #1;
      inputs = w[k][N-1:0];
      select_line = w[k][N];
      gamma_start = (k == ab) && !rst_abort;
      if (k == ab && rst_abort) grst_n = 1'b0;
      @(negedge clk);
      for (int e = 0; e < 3; e++) begin
        logic r;
        r = (e == 1);
        if (k == ab && rst_abort) begin
          chk("rst_busy", e, k, 8'(bs[e]), 8'd0);
          chk("rst_y", e, k, 8'(ys[e]), 8'(r));
        end else begin
          chk("busy", e, k, 8'(bs[e]), 8'd1);
          chk("y", e, k, 8'(ys[e]), 8'(act_exp(e, k, m[e]) ^ r));
        end
`ifdef MUX_T_TIMESTAMP_EN
        chk("mv_run", e, k, 8'(mv[e]), 8'd0);
`endif
      end
      if (k == ab) return;
    end
    @(posedge clk);
    #1;
    gamma_start = 1'b0;
    inputs = N'($urandom);
    select_line = 1'($urandom);
    @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      chk("end_busy", e, G, 8'(bs[e]), 8'd0);
      chk("end_y", e, G, 8'(ys[e]), 8'(e == 1));
`ifdef MUX_T_TIMESTAMP_EN
      chk("end_mv", e, G, 8'(mv[e]), 8'(m[e] >= 0));
      if (m[e] >= 0) begin
        chk("match_time", e, G, 8'(mt[e]), 8'(m[e]));
        chk("match_idx", e, G, 8'(mi[e]), 8'(ix[e]));
      end
`endif
    end
  endtask
  task automatic run(input int ab, input bit rst_abort);
    if (!pend) begin
      @(posedge clk);
      #1;
      gamma_start = 1'b1;
      inputs = N'($urandom);
      select_line = 1'($urandom);
    end
    gamma(ab, rst_abort);
    pend = ab >= 0 && !rst_abort;
    if (ab >= 0 && rst_abort) begin
      @(posedge clk);
      #1;
      grst_n = 1'b1;
      @(negedge clk);
      idle_chk("post_rst");
    end
  endtask
  initial begin
    @(negedge clk);
    idle_chk("reset");
    @(posedge clk);
    #1;
    grst_n = 1'b1;
    clr_w(); step(N, 5, 0); step(2, 5, 0); step(0, 3, 0); step(1, 9, 0);
    run(-1, 0);
    for (int l = 0; l <= N; l++) step(l, G, 1);
    step(N, 7, 1); step(0, 3, 1); step(1, 9, 1);
    run(-1, 0);
    clr_w(); step(N, 12, 0); step(0, 12, 0);
    run(-1, 0);
    clr_w(); step(N, 0, 0); step(1, 0, 0); step(3, 0, 0);
    run(-1, 0);
    clr_w(); step(N, 4, 0); step(3, 4, 0);
    run(6, 0);
    clr_w(); step(N, 2, 0); step(1, 2, 0);
    run(-1, 0);
    clr_w(); step(N, 3, 0); step(2, 3, 0);
    run(8, 1);
    repeat (24) begin
      int ab;
      bit ra;
      rand_w();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, G - 1)) : -1;
      ra = ab >= 0 && $urandom_range(0, 1) == 1;
      run(ab, ra);
    end
    if (pend) begin
      clr_w();
      run(-1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
